// File: rtl/alarm_timeout.sv
// Two-channel one-shot down-counter sharing one load interface: the alarm channel
// pulses bell for one cycle on expiry, the timeout channel sets a sticky full flag.
module alarm_timeout #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] value,
    input  logic         put,
    output logic         bell,
    output logic         full
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t         alarm_state, alarm_state_next;
    state_t         tmo_state, tmo_state_next;
    logic [W-1:0]   alarm_count, alarm_count_next;
    logic [W-1:0]   tmo_count, tmo_count_next;
    logic           alarm_expire, tmo_expire;
    logic           bell_next, full_next;

    // A count of 1 or 0 expires on the next edge, so a load of 0 behaves like 1.
    function automatic logic last_tick(input logic [W-1:0] count);
        return count <= W'(1);
    endfunction

    function automatic logic [W-1:0] dec_count(input logic [W-1:0] count);
        return last_tick(count) ? '0 : count - W'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            alarm_state <= IDLE;
            tmo_state   <= IDLE;
            alarm_count <= '0;
            tmo_count   <= '0;
            bell        <= 1'b0;
            full        <= 1'b0;
        end else begin
            alarm_state <= alarm_state_next;
            tmo_state   <= tmo_state_next;
            alarm_count <= alarm_count_next;
            tmo_count   <= tmo_count_next;
            bell        <= bell_next;
            full        <= full_next;
        end
    end

    // Alarm channel: a load always wins over an expiry on the same edge.
    always_comb begin
        alarm_state_next = alarm_state;
        alarm_count_next = alarm_count;
        alarm_expire     = 1'b0;
        if (put) begin
            alarm_state_next = ARMED;
            alarm_count_next = value;
        end else if (alarm_state == ARMED) begin
            alarm_count_next = dec_count(alarm_count);
            if (last_tick(alarm_count)) begin
                alarm_state_next = IDLE;
                alarm_expire     = 1'b1;
            end
        end
    end

    always_comb begin
        tmo_state_next = tmo_state;
        tmo_count_next = tmo_count;
        tmo_expire     = 1'b0;
        if (put) begin
            tmo_state_next = ARMED;
            tmo_count_next = value;
        end else if (tmo_state == ARMED) begin
            tmo_count_next = dec_count(tmo_count);
            if (last_tick(tmo_count)) begin
                tmo_state_next = IDLE;
                tmo_expire     = 1'b1;
            end
        end
    end

    // bell lives only on the expiry edge; full holds until the next load.
    always_comb begin
        bell_next = alarm_expire;
        full_next = full;
        if (put) begin
            full_next = 1'b0;
        end else if (tmo_expire) begin
            full_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_alarm_timeout.sv
// Directed bench for alarm_timeout: stimulus queues the hand-derived bell/full
// values expected after each edge, a monitor pops and compares them on the falling edge.
module tb_alarm_timeout;

    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic [W-1:0] value;
    logic         put;
    logic         bell;
    logic         full;

    typedef struct {
        logic  bell;
        logic  full;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   passed;
    int   total;
    bit   stim_done;

    alarm_timeout #(.W(W)) dut (
        .clock (clock),
        .reset (reset),
        .value (value),
        .put   (put),
        .bell  (bell),
        .full  (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock edge with the given inputs; push what the outputs must be after it.
    task automatic step(input string name, input logic r, input logic p,
                        input logic [W-1:0] v, input logic eb, input logic ef);
        exp_t e;
        reset = r;
        put   = p;
        value = v;
        @(posedge clock);
        e.bell = eb;
        e.full = ef;
        e.name = name;
        exp_q.push_back(e);
        #1;
    endtask

    // n idle edges; bell expected only on edge bell_at, full from edge full_at on
    // (0 = never), or throughout when full_pre is set.
    task automatic idle(input string name, input int n, input int bell_at,
                        input int full_at, input logic full_pre);
        for (int i = 1; i <= n; i++) begin
            step(name, 1'b0, 1'b0, W'($urandom_range(0, 255)),
                 (i == bell_at),
                 full_pre || (full_at != 0 && i >= full_at));
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                total++;
                if (bell === e.bell && full === e.full) begin
                    passed++;
                end else begin
                    $display("FAIL %s: bell=%b full=%b, required bell=%b full=%b at t=%0t",
                             e.name, bell, full, e.bell, e.full, $time);
                end
            end
        end
    end

    initial begin
        stim_done = 1'b0;
        reset = 1'b1;
        put   = 1'b0;
        value = '0;

        step("reset0", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step("reset1", 1'b1, 1'b1, 8'h05, 1'b0, 1'b0);

        step("load25", 1'b0, 1'b1, 8'h19, 1'b0, 1'b0);
        idle("run25", 25, 25, 25, 1'b0);
        idle("hold25", 3, 0, 0, 1'b1);

        step("load1", 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        idle("run1", 2, 1, 1, 1'b0);
        step("load0", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        idle("run0", 2, 1, 1, 1'b0);

        step("load10", 1'b0, 1'b1, 8'd10, 1'b0, 1'b0);
        idle("run10", 4, 0, 0, 1'b0);
        step("reload4", 1'b0, 1'b1, 8'd4, 1'b0, 1'b0);
        idle("run4", 7, 4, 4, 1'b0);

        step("load3", 1'b0, 1'b1, 8'd3, 1'b0, 1'b0);
        idle("run3", 2, 0, 0, 1'b0);
        step("reload_at_expiry", 1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
        idle("run2", 3, 2, 2, 1'b0);

        step("load8", 1'b0, 1'b1, 8'd8, 1'b0, 1'b0);
        idle("run8", 2, 0, 0, 1'b0);
        step("reset_mid", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        idle("after_reset", 17, 0, 0, 1'b0);
        step("load5a", 1'b0, 1'b1, 8'd5, 1'b0, 1'b0);
        idle("run5a", 6, 5, 5, 1'b0);

        step("load5b", 1'b0, 1'b1, 8'd5, 1'b0, 1'b0);
        idle("run5b", 6, 5, 5, 1'b0);
        step("reset_full", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        idle("idle_after_reset", 2, 0, 0, 1'b0);

        step("load6", 1'b0, 1'b1, 8'd6, 1'b0, 1'b0);
        idle("run6", 2, 0, 0, 1'b0);
        step("reset_and_put", 1'b1, 1'b1, 8'd2, 1'b0, 1'b0);
        idle("after_reset_put", 8, 0, 0, 1'b0);

        step("load255", 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        idle("run255", 257, 255, 255, 1'b0);

        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        wait (stim_done);
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clock);
            budget++;
        end
        if (exp_q.size() > 0) begin
            total++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, required completion");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1, "time limit");
    end

endmodule
